// File: rtl/seg7_pkg.sv
// Purpose : shared types and constants for the 7-segment scan controller slice.
// Latency : n/a (types, constants only).
// Backpressure: n/a.
// Contents: seg_t (segments a..g, index 0 = a, active-low), SEG_BLANK,
//           SEG_TABLE (BCD 0..9 glyphs), state_t (per-slot scan phase).
package seg7_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Active-low glyphs, bit order a,b,c,d,e,f,g.
    localparam seg_t SEG_TABLE [0:9] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100   // 9
    };

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Purpose : load handshake between the BCD datapath and the scan controller.
// Latency : n/a (wires only).
// Backpressure: ready low means a value is already pending; load is ignored then.
// Signals : load (request), bcd_in (packed BCD, digit 0 in [3:0]), ready (pending empty).
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
) ();

    logic                    load;
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    ready;

    modport master (output load, output bcd_in, input ready);
    modport slave  (input load, input bcd_in, output ready);

endinterface

// File: rtl/seg7_decode.sv
// Purpose : BCD nibble to active-low 7-segment glyph; codes 10..15 show nothing.
// Latency : combinational.
// Backpressure: none.
// Ports   : bcd (4b in), seg ([0:6] a..g out, active-low).
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd < 4'd10) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Purpose : time-multiplexes one decoder over NUM_DIGITS common-anode digits with blanking gaps and leading-zero blanking.
// Latency : an/seg registered, 1 cycle behind scan state; new value appears from digit 0 of the frame after commit.
// Backpressure: one pending slot; ready drops after an accepted load and returns after the frame-end commit.
// Ports   : clk, rst (sync, active-high), lif (load/bcd_in/ready, slave), an (active-low enables),
//           seg ([0:6] a..g, active-low), frame_tick (pulse in last cycle of last digit slot).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    parameter int BLANK_CYC  = 16,
    parameter int LZ_BLANK   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_scan_ctrl_if.slave       lif,
    output logic [NUM_DIGITS-1:0] an,
    output seg_t                  seg,
    output logic                  frame_tick
);

    localparam int PCNT_W = $clog2(PRESCALE);
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    // Scan state
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    state_t            st_q, st_d;
    logic              slot_end;
    logic              last_digit;

    // Output staging
    logic [NUM_DIGITS-1:0] an_d;
    seg_t                  seg_d;
    seg_t                  dec_seg;

    // Value buffers
    logic [NUM_DIGITS-1:0][3:0] disp_q;
    logic [NUM_DIGITS-1:0][3:0] pend_q;
    logic                       pend_full_q;

    // Leading-zero mask: bit i set when digit i and everything above it are zero
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;

    assign slot_end   = (pcnt_q == PCNT_W'(PRESCALE - 1));
    assign last_digit = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign frame_tick = slot_end && last_digit;
    assign lif.ready  = !pend_full_q;

    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run && (disp_q[i] == 4'd0);
            lz_mask[i] = zero_run && (LZ_BLANK != 0);
        end
    end

    seg7_decode u_decode (
        .bcd (disp_q[idx_q]),
        .seg (dec_seg)
    );

    // Next-state and output staging
    always_comb begin
        st_d   = st_q;
        pcnt_d = slot_end ? '0 : pcnt_q + 1'b1;
        idx_d  = idx_q;
        an_d   = '1;
        seg_d  = SEG_BLANK;

        if (slot_end) begin
            idx_d = last_digit ? '0 : idx_q + 1'b1;
        end

        case (st_q)
            ST_BLANK: begin
                // Slot end never falls inside the blank gap since PRESCALE > BLANK_CYC
                if (pcnt_q == PCNT_W'(BLANK_CYC - 1)) begin
                    st_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                an_d[idx_q] = 1'b0;
                if (!lz_mask[idx_q]) begin
                    seg_d = dec_seg;
                end
                if (slot_end) begin
                    st_d = ST_BLANK;
                end
            end
            default: st_d = ST_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= ST_BLANK;
            pcnt_q <= '0;
            idx_q  <= '0;
            an     <= '1;
            seg    <= SEG_BLANK;
        end else begin
            st_q   <= st_d;
            pcnt_q <= pcnt_d;
            idx_q  <= idx_d;
            an     <= an_d;
            seg    <= seg_d;
        end
    end

    // Accept and commit are mutually exclusive: accept needs the slot empty, commit needs it full.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
        end else begin
            if (lif.load && !pend_full_q) begin
                pend_q      <= lif.bcd_in;
                pend_full_q <= 1'b1;
            end
            if (frame_tick && pend_full_q) begin
                disp_q      <= pend_q;
                pend_full_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] an;
    logic [0:6] seg;
    logic       frame_tick;

    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.NUM_DIGITS(4)) lif ();

    seg7_scan_ctrl #(
        .NUM_DIGITS (4),
        .PRESCALE   (4),
        .BLANK_CYC  (1),
        .LZ_BLANK   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lif        (lif),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    localparam logic [6:0] BLANK7 = 7'b1111111;
    localparam logic [6:0] TBL [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   exp_pending = 1'b0;
    int   waited;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] exp_digit(input logic [15:0] v, input int d);
        logic [3:0] nib;
        nib = v[4*d +: 4];
        if (d > 0 && (v >> (4*d)) == 16'h0) return BLANK7;
        if (nib < 4'd10) return TBL[nib];
        return BLANK7;
    endfunction

    // One frame = 4 slots of 1 blank + 3 drive cycles
    task automatic push_frame(input logic [15:0] v);
        exp_t       e;
        logic [3:0] one;
        for (int d = 0; d < 4; d++) begin
            e.an  = 4'hF;
            e.seg = BLANK7;
            sb.push_back(e);
            one   = 4'b0001 << d;
            e.an  = ~one;
            e.seg = exp_digit(v, d);
            for (int k = 0; k < 3; k++) sb.push_back(e);
        end
    endtask

    task automatic load_val(input logic [15:0] v);
        lif.load   = 1'b1;
        lif.bcd_in = v;
        if (!exp_pending) begin
            push_frame(v);
            exp_pending = 1'b1;
        end
        tick();
        lif.load = 1'b0;
    endtask

    task automatic wait_frame(output int w);
        w = 0;
        while (frame_tick !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        chk("frame_tick_seen", frame_tick, 1);
    endtask

    task automatic commit_and_check(input string tag, output int w);
        exp_t e;
        wait_frame(w);
        tick();
        exp_pending = 1'b0;
        chk({tag, "_ready"}, lif.ready, 1);
        for (int i = 0; i < 16; i++) begin
            tick();
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s_sb_empty: observed=0 entries expected>0", tag);
            end else begin
                e = sb.pop_front();
                chk({tag, "_an"}, an, e.an);
                chk({tag, "_seg"}, seg, e.seg);
                chk({tag, "_ft"}, frame_tick, (i == 14) ? 1 : 0);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        lif.load   = 1'b0;
        lif.bcd_in = '0;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, BLANK7);
        chk("rst_ready", lif.ready, 1);
        chk("rst_ft", frame_tick, 0);
        tick();
        chk("first_blank_an", an, 4'hF);
        tick();
        chk("first_drive_an", an, 4'hE);
        chk("first_drive_seg", seg, 7'b0000001);

        // Plain value
        load_val(16'h1234);
        chk("load1234_ready", lif.ready, 0);
        commit_and_check("v1234", waited);

        // Load accepted on the frame_tick cycle waits a whole extra frame
        wait_frame(waited);
        load_val(16'h0070);
        chk("sim_ready", lif.ready, 0);
        commit_and_check("v0070", waited);
        chk("sim_commit_delay", waited, 15);

        // Second load while pending is dropped
        load_val(16'h9999);
        chk("col_ready1", lif.ready, 0);
        load_val(16'h5555);
        chk("col_ready2", lif.ready, 0);
        commit_and_check("v9999", waited);

        // Invalid code and zero/interior-zero patterns
        load_val(16'h00A0);
        commit_and_check("v00A0", waited);
        load_val(16'h0000);
        commit_and_check("v0000", waited);
        load_val(16'h8005);
        commit_and_check("v8005", waited);

        // Reset during DRIVE of digit 2 with a value pending
        wait_frame(waited);
        repeat (9) tick();
        lif.load   = 1'b1;
        lif.bcd_in = 16'h8888;
        tick();
        lif.load = 1'b0;
        chk("mid_ready", lif.ready, 0);
        tick();
        chk("mid_an", an, 4'hB);
        chk("mid_seg", seg, exp_digit(16'h8005, 2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_an", an, 4'hF);
        chk("mrst_seg", seg, BLANK7);
        chk("mrst_ready", lif.ready, 1);
        chk("mrst_ft", frame_tick, 0);
        tick();
        chk("mrst_blank_an", an, 4'hF);
        tick();
        chk("mrst_drive_an", an, 4'hE);
        chk("mrst_drive_seg", seg, 7'b0000001);
        wait_frame(waited);
        chk("mrst_frame_len", waited, 13);
        repeat (3) tick();
        chk("discard_an", an, 4'hE);
        chk("discard_seg", seg, 7'b0000001);
        chk("discard_ready", lif.ready, 1);

        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
